// File: rtl/cpucmd_writer_pkg.sv
// cpucmd_writer_pkg
// Shared definitions for the CPU-to-host command FIFO writer: FSM state
// encoding, header sync byte, header field offsets, packet-type codes and
// the header packing helper.
package cpucmd_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Header word layout, MSB first: {sync, type, len, seq}
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_TYPE_LSB = 16;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_SEQ_LSB  = 0;

    localparam logic [7:0] PKT_REG_RD_RESP = 8'h01;
    localparam logic [7:0] PKT_STATUS      = 8'h02;
    localparam logic [7:0] PKT_PING        = 8'h7F;

    function automatic logic [31:0] pkt_hdr_pack(
        input logic [7:0] sync_byte,
        input logic [7:0] pkt_type,
        input logic [7:0] pkt_len,
        input logic [7:0] seq
    );
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 8] = sync_byte;
        hdr[HDR_TYPE_LSB +: 8] = pkt_type;
        hdr[HDR_LEN_LSB  +: 8] = pkt_len;
        hdr[HDR_SEQ_LSB  +: 8] = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/cpucmd_writer.sv
// cpucmd_writer
// Frames command/response packets into cpucmd_fifo: header word, payload
// words, then an XOR checksum of header and payload. Every write is gated
// combinationally by the FIFO full flag.
//
// Ports:
//   clk          system clock (cpucmd_fifo WrClock)
//   reset_n      asynchronous active-low reset
//   start_i      packet request, sampled only in IDLE
//   pkt_type_i   packet type, latched on accept
//   pkt_len_i    payload word count, latched (clamped to MAX_LEN) on accept
//   pl_data_i    payload word
//   pl_valid_i   payload word valid
//   pl_ready_o   payload word consumed when high with pl_valid_i
//   busy_o       packet in flight (registered)
//   done_o       pulse in the cycle the checksum word is written
//   drop_o       sticky: a request arrived while not idle
//   seq_o        sequence number the next packet will carry
//   fifo_data_o  FIFO write data
//   fifo_we_o    FIFO write enable
//   fifo_full_i  FIFO full flag
//
// state | meaning
// IDLE  | waiting for start_i; nothing written
// HDR   | writing header word {sync, type, len, seq}
// PAY   | passing payload words through to the FIFO
// CSUM  | writing XOR checksum word, then back to IDLE
module cpucmd_writer
    import cpucmd_writer_pkg::*;
#(
    parameter int         FT_DATA_WIDTH = 32,   // header layout needs 32
    parameter int         MAX_LEN       = 255,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [7:0]               pkt_type_i,
    input  logic [7:0]               pkt_len_i,
    input  logic [FT_DATA_WIDTH-1:0] pl_data_i,
    input  logic                     pl_valid_i,
    output logic                     pl_ready_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     drop_o,
    output logic [7:0]               seq_o,
    output logic [FT_DATA_WIDTH-1:0] fifo_data_o,
    output logic                     fifo_we_o,
    input  logic                     fifo_full_i
);

    localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);

    state_e                   state_q, state_d;
    logic [7:0]               type_q, type_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               rem_q, rem_d;
    logic [7:0]               seq_q, seq_d;
    logic [FT_DATA_WIDTH-1:0] csum_q, csum_d;
    logic                     busy_q, busy_d;
    logic                     drop_q, drop_d;

    logic [7:0]               len_clamped;
    logic [FT_DATA_WIDTH-1:0] hdr_word;

    assign len_clamped = (pkt_len_i > MAX_LEN_L) ? MAX_LEN_L : pkt_len_i;
    assign hdr_word    = FT_DATA_WIDTH'(pkt_hdr_pack(SYNC_BYTE, type_q, len_q, seq_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        len_d       = len_q;
        rem_d       = rem_q;
        seq_d       = seq_q;
        csum_d      = csum_q;
        pl_ready_o  = 1'b0;
        fifo_we_o   = 1'b0;
        fifo_data_o = '0;
        done_o      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    type_d  = pkt_type_i;
                    len_d   = len_clamped;
                    rem_d   = len_clamped;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                fifo_data_o = hdr_word;
                if (!fifo_full_i) begin
                    fifo_we_o = 1'b1;
                    csum_d    = hdr_word;
                    seq_d     = seq_q + 8'd1;
                    state_d   = (len_q != 8'd0) ? ST_PAY : ST_CSUM;
                end
            end
            ST_PAY: begin
                pl_ready_o  = ~fifo_full_i;
                fifo_data_o = pl_data_i;
                if (pl_valid_i && !fifo_full_i) begin
                    fifo_we_o = 1'b1;
                    csum_d    = csum_q ^ pl_data_i;
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                fifo_data_o = csum_q;
                if (!fifo_full_i) begin
                    fifo_we_o = 1'b1;
                    done_o    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy_q follows the next state so it rises the cycle after accept and
    // falls the cycle after the checksum write.
    assign busy_d = (state_d != ST_IDLE);
    // A request that arrives mid-packet is discarded and only flagged.
    assign drop_d = drop_q | (start_i && (state_q != ST_IDLE));

    assign busy_o = busy_q;
    assign drop_o = drop_q;
    assign seq_o  = seq_q;

endmodule

// File: tb/tb_cpucmd_writer.sv
module tb_cpucmd_writer;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic [7:0]  pkt_type_i;
    logic [7:0]  pkt_len_i;
    logic [31:0] pl_data_i;
    logic        pl_valid_i;
    logic        pl_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        drop_o;
    logic [7:0]  seq_o;
    logic [31:0] fifo_data_o;
    logic        fifo_we_o;
    logic        fifo_full_i;

    int checks = 0;
    int errors = 0;

    cpucmd_writer #(
        .FT_DATA_WIDTH(32),
        .MAX_LEN(255),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start_i(start_i),
        .pkt_type_i(pkt_type_i),
        .pkt_len_i(pkt_len_i),
        .pl_data_i(pl_data_i),
        .pl_valid_i(pl_valid_i),
        .pl_ready_o(pl_ready_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .drop_o(drop_o),
        .seq_o(seq_o),
        .fifo_data_o(fifo_data_o),
        .fifo_we_o(fifo_we_o),
        .fifo_full_i(fifo_full_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  typ;
        logic [7:0]  len;
        logic [31:0] pdata;
        logic        pvalid;
        logic        full;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic        exp_done;
        logic        exp_busy;
        logic [7:0]  exp_seq;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic start, input logic [7:0] typ, input logic [7:0] len,
        input logic [31:0] pdata, input logic pvalid, input logic full,
        input logic exp_we, input logic [31:0] exp_data, input logic exp_ready,
        input logic exp_done, input logic exp_busy, input logic [7:0] exp_seq
    );
        vec_t v;
        v.start = start;   v.typ = typ;           v.len = len;
        v.pdata = pdata;   v.pvalid = pvalid;     v.full = full;
        v.exp_we = exp_we; v.exp_data = exp_data; v.exp_ready = exp_ready;
        v.exp_done = exp_done; v.exp_busy = exp_busy; v.exp_seq = exp_seq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive just after the rising edge, return at the falling edge
    // so combinational outputs have settled for sampling.
    task automatic cyc(input logic start, input logic [7:0] typ, input logic [7:0] len,
                       input logic [31:0] pdata, input logic pvalid, input logic full);
        @(posedge clk);
        #1;
        start_i     = start;
        pkt_type_i  = typ;
        pkt_len_i   = len;
        pl_data_i   = pdata;
        pl_valid_i  = pvalid;
        fifo_full_i = full;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int wr_cnt;
        int busy_seen;

        reset_n     = 1'b0;
        start_i     = 1'b0;
        pkt_type_i  = '0;
        pkt_len_i   = '0;
        pl_data_i   = '0;
        pl_valid_i  = 1'b0;
        fifo_full_i = 1'b0;

        // Scenarios: basic len-2 packet (seq 0), zero-length ping (seq 1),
        // len-2 packet with full stalls in PAY and CSUM (seq 2), then idle.
        vecs[0]  = mk(1, 8'h01, 8'd2, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 8'd0);
        vecs[1]  = mk(0, 8'h01, 8'd2, 32'h0,        0, 0, 1, 32'hA5010200, 0, 0, 1, 8'd0);
        vecs[2]  = mk(0, 8'h00, 8'd0, 32'h11223344, 1, 0, 1, 32'h11223344, 1, 0, 1, 8'd1);
        vecs[3]  = mk(0, 8'h00, 8'd0, 32'h55667788, 1, 0, 1, 32'h55667788, 1, 0, 1, 8'd1);
        vecs[4]  = mk(0, 8'h00, 8'd0, 32'h0,        0, 0, 1, 32'hE14546CC, 0, 1, 1, 8'd1);
        vecs[5]  = mk(1, 8'h7F, 8'd0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 8'd1);
        vecs[6]  = mk(0, 8'h00, 8'd0, 32'h0,        0, 0, 1, 32'hA57F0001, 0, 0, 1, 8'd1);
        vecs[7]  = mk(0, 8'h00, 8'd0, 32'h0,        0, 0, 1, 32'hA57F0001, 0, 1, 1, 8'd2);
        vecs[8]  = mk(1, 8'h01, 8'd2, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 8'd2);
        vecs[9]  = mk(0, 8'h00, 8'd0, 32'h0,        0, 0, 1, 32'hA5010202, 0, 0, 1, 8'd2);
        vecs[10] = mk(0, 8'h00, 8'd0, 32'h11223344, 1, 1, 0, 32'h11223344, 0, 0, 1, 8'd3);
        vecs[11] = mk(0, 8'h00, 8'd0, 32'h11223344, 1, 1, 0, 32'h11223344, 0, 0, 1, 8'd3);
        vecs[12] = mk(0, 8'h00, 8'd0, 32'h11223344, 1, 1, 0, 32'h11223344, 0, 0, 1, 8'd3);
        vecs[13] = mk(0, 8'h00, 8'd0, 32'h11223344, 1, 0, 1, 32'h11223344, 1, 0, 1, 8'd3);
        vecs[14] = mk(0, 8'h00, 8'd0, 32'h55667788, 1, 0, 1, 32'h55667788, 1, 0, 1, 8'd3);
        vecs[15] = mk(0, 8'h00, 8'd0, 32'h0,        0, 1, 0, 32'hE14546CE, 0, 0, 1, 8'd3);
        vecs[16] = mk(0, 8'h00, 8'd0, 32'h0,        0, 1, 0, 32'hE14546CE, 0, 0, 1, 8'd3);
        vecs[17] = mk(0, 8'h00, 8'd0, 32'h0,        0, 1, 0, 32'hE14546CE, 0, 0, 1, 8'd3);
        vecs[18] = mk(0, 8'h00, 8'd0, 32'h0,        0, 0, 1, 32'hE14546CE, 0, 1, 1, 8'd3);
        vecs[19] = mk(0, 8'h00, 8'd0, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0, 0, 0, 8'd3);

        // Reset state
        @(negedge clk);
        chk("rst we",    32'(fifo_we_o),  32'd0);
        chk("rst data",  fifo_data_o,     32'd0);
        chk("rst busy",  32'(busy_o),     32'd0);
        chk("rst done",  32'(done_o),     32'd0);
        chk("rst drop",  32'(drop_o),     32'd0);
        chk("rst seq",   32'(seq_o),      32'd0);
        chk("rst ready", 32'(pl_ready_o), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].start, vecs[i].typ, vecs[i].len,
                vecs[i].pdata, vecs[i].pvalid, vecs[i].full);
            chk($sformatf("vec%0d we",    i), 32'(fifo_we_o),  32'(vecs[i].exp_we));
            chk($sformatf("vec%0d data",  i), fifo_data_o,     vecs[i].exp_data);
            chk($sformatf("vec%0d ready", i), 32'(pl_ready_o), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d done",  i), 32'(done_o),     32'(vecs[i].exp_done));
            chk($sformatf("vec%0d busy",  i), 32'(busy_o),     32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d seq",   i), 32'(seq_o),      32'(vecs[i].exp_seq));
        end
        chk("tbl drop", 32'(drop_o), 32'd0);

        // Bubbles and a mid-packet start: len 3, seq 3, payload 1,2,4.
        // Checksum A5020303 ^ 1 ^ 2 ^ 4 = A5020304.
        cyc(1, 8'h02, 8'd3, 32'h0, 0, 0);
        cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
        chk("bub hdr", fifo_data_o, 32'hA5020303);
        wr_cnt = 0;
        cyc(0, 8'h00, 8'd0, 32'h1, 1, 0);
        wr_cnt += int'(fifo_we_o);
        cyc(1, 8'h02, 8'd9, 32'h0, 0, 0);
        wr_cnt += int'(fifo_we_o);
        chk("bub gap ready", 32'(pl_ready_o), 32'd1);
        cyc(0, 8'h00, 8'd0, 32'h2, 1, 0);
        wr_cnt += int'(fifo_we_o);
        chk("bub drop set", 32'(drop_o), 32'd1);
        cyc(0, 8'h00, 8'd0, 32'h4, 1, 0);
        wr_cnt += int'(fifo_we_o);
        chk("bub pay writes", 32'(wr_cnt), 32'd3);
        cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
        chk("bub csum", fifo_data_o, 32'hA5020304);
        chk("bub done", 32'(done_o), 32'd1);
        busy_seen = 0;
        wr_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
            busy_seen += int'(busy_o);
            wr_cnt += int'(fifo_we_o);
        end
        chk("bub no 2nd pkt busy", 32'(busy_seen), 32'd0);
        chk("bub no 2nd pkt we",   32'(wr_cnt),    32'd0);
        chk("bub drop sticky",     32'(drop_o),    32'd1);
        chk("bub seq",             32'(seq_o),     32'd4);

        // Reset mid-packet: len 4, seq 4, reset during PAY.
        cyc(1, 8'h02, 8'd4, 32'h0, 0, 0);
        cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
        chk("rmp hdr", fifo_data_o, 32'hA5020404);
        cyc(0, 8'h00, 8'd0, 32'hCAFE0001, 1, 0);
        cyc(0, 8'h00, 8'd0, 32'hCAFE0002, 1, 0);
        chk("rmp pay we", 32'(fifo_we_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmp async we", 32'(fifo_we_o), 32'd0);
        chk("rmp busy",     32'(busy_o),    32'd0);
        chk("rmp seq",      32'(seq_o),     32'd0);
        chk("rmp drop",     32'(drop_o),    32'd0);
        @(posedge clk);
        #1;
        pl_valid_i = 1'b0;
        reset_n = 1'b1;
        cyc(1, 8'h7F, 8'd0, 32'h0, 0, 0);
        cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
        chk("rmp next hdr", fifo_data_o, 32'hA57F0000);
        cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
        chk("rmp next done", 32'(done_o), 32'd1);

        // Sequence wrap: 257 back-to-back zero-length packets from seq 0.
        do_reset();
        for (int p = 0; p < 257; p++) begin
            logic [7:0] s;
            s = 8'(p);
            cyc(1, 8'h7F, 8'd0, 32'h0, 0, 0);
            chk($sformatf("wrap%0d idle we", p),   32'(fifo_we_o), 32'd0);
            chk($sformatf("wrap%0d idle busy", p), 32'(busy_o),    32'd0);
            cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
            chk($sformatf("wrap%0d hdr", p), fifo_data_o, {8'hA5, 8'h7F, 8'h00, s});
            cyc(0, 8'h00, 8'd0, 32'h0, 0, 0);
            chk($sformatf("wrap%0d done", p), 32'(done_o), 32'd1);
        end
        chk("wrap final seq", 32'(seq_o),  32'd1);
        chk("wrap drop",      32'(drop_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Write safety: never a write while the FIFO reports full.
    always @(negedge clk) begin
        if (fifo_we_o && fifo_full_i) begin
            errors++;
            $display("FAIL write_while_full actual=1 required=0");
        end
    end

endmodule
